// File: rtl/jtframe_rst_pkg.sv
// jtframe_rst_pkg: shared definitions for the reset sequencer.
// FSM state encodings and parameter limits used by jtframe_rstseq.
package jtframe_rst_pkg;

    // Sequencer states: hold all resets, release channels one by one, idle.
    typedef enum logic [1:0] {
        ASRT    = 2'd0,
        STRETCH = 2'd1,
        RUN     = 2'd2
    } rstseq_state_t;

    // Largest supported channel count and shallowest safe synchroniser.
    localparam int MAX_CH   = 8;
    localparam int MIN_SYNC = 2;

    // Index width for a CH-channel sequencer; one bit even for a single channel.
    function automatic int idx_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rstseq_sync.sv
// jtframe_rstseq_sync: W-wide, DEPTH-deep synchroniser for reset requests.
// A synchronous rst presets every stage to 1, so a block reset reads as an
// active request until DEPTH clean samples have flushed the chain.
module jtframe_rstseq_sync
    import jtframe_rst_pkg::*;
#(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    localparam int D = (DEPTH < MIN_SYNC) ? MIN_SYNC : DEPTH;

    logic [D-1:0][W-1:0] stages;

    // Shift each source bit through D flops; preset to "request" on rst.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every stage sample the old value
        // of its predecessor, which is what makes this a shift chain.
        if (rst) begin
            stages <= '1;
        end else begin
            stages <= {stages[D-2:0], din};
        end
    end

    assign dout = stages[D-1];

endmodule

// File: rtl/jtframe_rstseq.sv
// jtframe_rstseq: sequenced reset release for CH channels.
// Any synchronised request forces all channels into reset; once requests
// clear, channel k is held for lens[k]+1 cen-qualified cycles in turn.
// Optional feature macro: JTFRAME_RSTSEQ_FLIP_EN (flip DIP change acts as a
// one-cycle reset request).
module jtframe_rstseq
    import jtframe_rst_pkg::*;
#(
    parameter int CH   = 4,
    parameter int CNTW = 8,
    parameter int SRCN = 4,
    parameter int SYNC = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic [SRCN-1:0]    src,
    input  logic [CH*CNTW-1:0] lens,
    input  logic               flip,
    output logic [CH-1:0]      rst_out,
    output logic [CH-1:0]      rst_n_out,
    output logic               busy,
    output logic               done
);

    localparam int IDXW = idx_width(CH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CH - 1);

    rstseq_state_t   state;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;
    logic [SRCN-1:0] src_sync;
    logic            flip_pulse;
    logic            any_src;

    jtframe_rstseq_sync #(
        .W     (SRCN),
        .DEPTH (SYNC)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (src),
        .dout (src_sync)
    );

`ifdef JTFRAME_RSTSEQ_FLIP_EN
    logic flip_q;
    logic flip_qq;

    // Two-flop history of the DIP level; a difference marks a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            flip_q  <= flip;
            flip_qq <= flip;
        end else begin
            flip_q  <= flip;
            flip_qq <= flip_q;
        end
    end

    assign flip_pulse = flip_q ^ flip_qq;
`else
    logic unused_flip;

    assign unused_flip = flip;
    assign flip_pulse  = 1'b0;
`endif

    assign any_src = (|src_sync) | flip_pulse;

    // Sequencer FSM with registered outputs; a request always wins over a release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ASRT;
            idx       <= '0;
            cnt       <= '0;
            rst_out   <= '1;
            rst_n_out <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (any_src) begin
                state     <= ASRT;
                idx       <= '0;
                cnt       <= '0;
                rst_out   <= '1;
                rst_n_out <= '0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ASRT: begin
                        state <= STRETCH;
                        idx   <= '0;
                        cnt   <= lens[CNTW-1:0];
                        busy  <= 1'b1;
                    end
                    STRETCH: begin
                        if (cen) begin
                            if (cnt != '0) begin
                                cnt <= cnt - 1'b1;
                            end else begin
                                rst_out[idx]   <= 1'b0;
                                rst_n_out[idx] <= 1'b1;
                                if (idx == LAST_IDX) begin
                                    state <= RUN;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end else begin
                                    idx <= idx + 1'b1;
                                    cnt <= lens[(int'(idx) + 1) * CNTW +: CNTW];
                                end
                            end
                        end
                    end
                    RUN: begin
                        busy <= 1'b0;
                    end
                    default: begin
                        state     <= ASRT;
                        idx       <= '0;
                        cnt       <= '0;
                        rst_out   <= '1;
                        rst_n_out <= '0;
                        busy      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtframe_rstseq.sv
// tb_jtframe_rstseq: self-checking bench for jtframe_rstseq (CH=4, CNTW=4).
// Reference model: per channel, count down lens+1 cen edges from the load
// edge; requests are delayed SYNC edges and abort everything.
module tb_jtframe_rstseq;

    localparam int CH   = 4;
    localparam int CNTW = 4;
    localparam int SRCN = 4;
    localparam int SYNC = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               cen;
    logic [SRCN-1:0]    src;
    logic [CH*CNTW-1:0] lens;
    logic               flip;
    logic [CH-1:0]      rst_out;
    logic [CH-1:0]      rst_n_out;
    logic               busy;
    logic               done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    int            m_phase;   // 0 = asserting, 1 = sequencing, 2 = running
    int            m_k;
    int            m_rem;     // cen edges left before channel m_k releases
    logic [CH-1:0] m_mask;
    logic          m_done;
    bit [SYNC-1:0] m_req;     // delay line of the OR of all requests
    logic          m_fq, m_fqq;

    jtframe_rstseq #(
        .CH   (CH),
        .CNTW (CNTW),
        .SRCN (SRCN),
        .SYNC (SYNC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .src       (src),
        .lens      (lens),
        .flip      (flip),
        .rst_out   (rst_out),
        .rst_n_out (rst_n_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic int len_of(input int k);
        return int'(lens[k*CNTW +: CNTW]);
    endfunction

    function automatic void model_edge();
        logic req;
        if (rst) begin
            m_phase = 0; m_k = 0; m_rem = 0;
            m_mask = '1; m_done = 1'b0; m_req = '1;
            m_fq = flip; m_fqq = flip;
            return;
        end
        req = m_req[SYNC-1];
`ifdef JTFRAME_RSTSEQ_FLIP_EN
        req = req | (m_fq ^ m_fqq);
`endif
        m_fqq = m_fq;
        m_fq  = flip;
        m_req = {m_req[SYNC-2:0], |src};
        m_done = 1'b0;
        if (req) begin
            m_phase = 0; m_k = 0; m_mask = '1;
        end else if (m_phase == 0) begin
            m_phase = 1; m_k = 0; m_rem = len_of(0) + 1;
        end else if (m_phase == 1 && cen) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_mask[m_k] = 1'b0;
                if (m_k == CH - 1) begin
                    m_phase = 2;
                    m_done  = 1'b1;
                end else begin
                    m_k   = m_k + 1;
                    m_rem = len_of(m_k) + 1;
                end
            end
        end
    endfunction

    function automatic logic [2*CH+1:0] exp_vec();
        return {m_mask, ~m_mask, (m_phase != 2), m_done};
    endfunction

    function automatic logic [2*CH+1:0] obs_vec();
        return {rst_out, rst_n_out, busy, done};
    endfunction

    // Advance one edge, update the model, then settle before sampling.
    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; src = '0; flip = 1'b0; lens = 16'h0123;
        step();
        step();
        tests++;
        if (obs_vec() !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_state got=%b exp=%b", obs_vec(), {4'hF, 4'h0, 1'b1, 1'b0});
        end
        // Held in reset for a while: nothing moves.
        step();
        tests++;
        if (obs_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_hold got=%b exp=%b", obs_vec(), exp_vec());
        end
    endtask

    // lens {0,1,2,3} (ch3..ch0): entry at SYNC+1 edges after rst falls,
    // then releases after 4, 3, 2, 1 cen edges.
    task automatic test_directed_sequence();
        int rel[CH];
        int e;
        logic [CH-1:0] em;
        lens = 16'h0123; cen = 1'b1; src = '0;
        rst = 1'b0;
        e = SYNC + 1;
        for (int k = 0; k < CH; k++) begin
            e = e + int'(lens[k*CNTW +: CNTW]) + 1;
            rel[k] = e;
        end
        for (int n = 1; n <= 18; n++) begin
            step();
            for (int k = 0; k < CH; k++) em[k] = (n < rel[k]);
            tests++;
            if (obs_vec() !== {em, ~em, (n < rel[CH-1]), (n == rel[CH-1])}) begin
                fails++;
                $display("FAIL directed_seq edge=%0d got=%b exp=%b", n, obs_vec(),
                         {em, ~em, (n < rel[CH-1]), (n == rel[CH-1])});
            end
        end
    endtask

    task automatic test_cen_thirds();
        lens = 16'h0123; src = '0; cen = 1'b1;
        pulse_rst();
        for (int i = 0; i < 60; i++) begin
            cen = (i % 3 == 0);
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL cen_thirds cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        cen = 1'b1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL cen_thirds_end busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_src_abort();
        int guard;
        int dones;
        lens = 16'h0123; src = '0; cen = 1'b1;
        pulse_rst();
        guard = 0;
        while (rst_out !== 4'b1100 && guard < 40) begin
            step();
            guard++;
        end
        tests++;
        if (rst_out !== 4'b1100) begin
            fails++;
            $display("FAIL abort_setup timeout got=%b exp=1100", rst_out);
        end
        src = 4'b0100;
        for (int j = 1; j <= 3; j++) begin
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL abort_window j=%0d got=%b exp=%b", j, obs_vec(), exp_vec());
            end
            if (j == SYNC + 1) begin
                tests++;
                if ({rst_out, done} !== {4'hF, 1'b0}) begin
                    fails++;
                    $display("FAIL abort_latency got=%b exp=%b", {rst_out, done}, {4'hF, 1'b0});
                end
            end
        end
        src = '0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) dones++;
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL abort_reseq cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
        tests++;
        if (dones != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_reseq_end dones=%0d busy=%b exp dones=1 busy=0", dones, busy);
        end
    endtask

    task automatic test_rst_in_run();
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests++;
        if (obs_vec() !== {4'hF, 4'h0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL rst_in_run got=%b exp=%b", obs_vec(), {4'hF, 4'h0, 1'b1, 1'b0});
        end
        for (int i = 0; i < 30; i++) begin
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL rst_restart cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_flip();
        flip = ~flip;
        for (int i = 0; i < 30; i++) begin
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL flip cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
            end
        end
`ifndef JTFRAME_RSTSEQ_FLIP_EN
        tests++;
        if (rst_out !== '0) begin
            fails++;
            $display("FAIL flip_ignored rst_out got=%b exp=0000", rst_out);
        end
`endif
    endtask

    // All lengths zero: channels release on consecutive edges after entry.
    task automatic test_len_zero();
        lens = '0; cen = 1'b1; src = '0;
        pulse_rst();
        for (int n = 1; n <= SYNC + 1 + CH; n++) begin
            step();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL len_zero edge=%0d got=%b exp=%b", n, obs_vec(), exp_vec());
            end
        end
        tests++;
        if ({rst_out, busy, done} !== {4'h0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL len_zero_done got=%b exp=%b", {rst_out, busy, done}, {4'h0, 1'b0, 1'b1});
        end
    endtask

    task automatic test_random();
        int hold;
        for (int r = 0; r < 10; r++) begin
            lens = 16'($urandom);
            src  = '0;
            pulse_rst();
            hold = 0;
            for (int i = 0; i < 200; i++) begin
                lens = 16'($urandom);
                cen  = ($urandom_range(0, 3) != 0);
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) src = '0;
                end else if ($urandom_range(0, 99) == 0) begin
                    src  = 4'($urandom_range(1, 15));
                    hold = $urandom_range(2, 4);
                end
                step();
                tests++;
                if (obs_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL random r=%0d i=%0d got=%b exp=%b", r, i, obs_vec(), exp_vec());
                end
            end
        end
        src = '0; cen = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed_sequence();
        test_cen_thirds();
        test_src_abort();
        test_rst_in_run();
        test_flip();
        test_len_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jtframe_rstseq.md
JTFRAME_RSTSEQ -- requirements
Module: jtframe_rstseq

Interface
REQ-001 Parameter CH, default 4: number of sequenced reset channels (1..8).
REQ-002 Parameter CNTW, default 8: width of each per-channel stretch length and of the stretch counter.
REQ-003 Parameter SRCN, default 4: number of asynchronous reset-request sources.
REQ-004 Parameter SYNC, default 2: synchroniser stages per source (minimum 2).
REQ-005 clk  in  1  single system clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high block reset.
REQ-007 cen  in  1  count enable; the stretch counter advances only when it is high.
REQ-008 src  in  SRCN  asynchronous active-high reset requests, OR-combined after synchronisation.
REQ-009 lens  in  CH*CNTW  per-channel stretch lengths; channel k occupies bits [k*CNTW +: CNTW].
REQ-010 flip  in  1  flip DIP level (used only with JTFRAME_RSTSEQ_FLIP_EN).
REQ-011 rst_out  out  CH  registered active-high resets, one per channel.
REQ-012 rst_n_out  out  CH  bitwise complement of rst_out, registered in the same cycle.
REQ-013 busy  out  1  high whenever the state is not RUN.
REQ-014 done  out  1  one-cycle pulse when the last channel is released.

Function
REQ-015 Each src bit shall pass through SYNC flops; any_src is the OR of the final stages (plus flip_pulse when enabled).
REQ-016 The FSM shall have three states: ASRT, STRETCH and RUN.
REQ-017 ASRT: all rst_out bits are 1; when any_src is 0, the next state is STRETCH with idx=0 and cnt=lens[0].
REQ-018 STRETCH, cen=1, cnt!=0: cnt decrements by 1.
REQ-019 STRETCH, cen=1, cnt==0: rst_out[idx] clears next cycle; if idx<CH-1, idx increments and cnt loads lens[idx+1]; otherwise the state becomes RUN and done pulses.
REQ-020 STRETCH, cen=0: cnt, idx and outputs hold.
REQ-021 Channel k shall release exactly lens[k]+1 cen-qualified cycles after its length is loaded; a length of 0 releases on the first cen.
REQ-022 Lower-index channels release first; once cleared, a channel stays released until the next ASRT.
REQ-023 lens shall be sampled only at load time; changes mid-count take effect at the next load.
REQ-024 any_src=1 in STRETCH or RUN shall force ASRT on the next edge: all rst_out become 1, idx=0 and no done pulse is issued. This takes priority over a simultaneous release.
REQ-025 A src pulse shorter than one clk period is not guaranteed to be captured; pulses of at least 2 clk periods shall be captured.
REQ-026 Assertion latency: rst_out reaches all-ones SYNC+1 edges after src is first sampled high.

Reset
REQ-027 rst=1 shall set the state to ASRT, rst_out to all ones, rst_n_out to all zeros, busy=1, done=0, idx=0 and cnt=0.
REQ-028 rst=1 shall also load all synchroniser flops with 1, so sequencing starts SYNC edges after rst falls, provided src is low.

Configuration
REQ-029 With JTFRAME_RSTSEQ_FLIP_EN defined, flip shall be registered, and a change of level shall produce a one-cycle flip_pulse that is ORed into any_src.
REQ-030 Without JTFRAME_RSTSEQ_FLIP_EN, flip shall be ignored, flip_pulse shall be 0, and no flip flops shall be inferred.

Structure
REQ-031 Package jtframe_rst_pkg shall hold the FSM state encodings (ASRT=2'd0, STRETCH=2'd1, RUN=2'd2) and the limit constants MAX_CH=8 and MIN_SYNC=2.
REQ-032 Sub-module jtframe_rstseq_sync shall be an SRCN-wide, SYNC-deep synchroniser with a synchronous preset on rst; everything else stays in jtframe_rstseq.

Verification
REQ-033 CH=4, CNTW=4, lens={0,1,2,3} (ch3..ch0), cen=1: after the STRETCH entry edge E0, channels release at E4, E7, E9 and E10; done pulses at E10.
REQ-034 Same configuration, cen high one cycle in three: each release interval is stretched ×3 and outputs hold while cen=0.
REQ-035 src[2] rises for 3 cycles while the FSM is in STRETCH with ch0 and ch1 released: all rst_out return to 1 at SYNC+1 edges, there is no done pulse, and a full resequence follows.
REQ-036 rst asserted in RUN for 1 cycle: outputs go all ones next edge, and sequencing restarts SYNC edges after rst falls.
REQ-037 FLIP_EN defined, flip toggles once in RUN: a full ASRT→STRETCH→RUN cycle runs. Without FLIP_EN, the same toggle leaves rst_out=0.
REQ-038 Random lens changes during STRETCH: each channel's interval uses the value present at its load edge only.
